// File: rtl/alu_share_arbiter.sv
// Round-robin share of the EX-stage ALU between the main pipeline (port 0)
// and an auxiliary requester (port 1), with a one-entry response buffer per port.
module alu_share_arbiter #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [3:0]       req0_op,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [3:0]       req1_op,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [31:0]      rsp0_result,
   output logic [3:0]       rsp0_flags,
   output logic [TAG_W-1:0] rsp0_tag,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [31:0]      rsp1_result,
   output logic [3:0]       rsp1_flags,
   output logic [TAG_W-1:0] rsp1_tag,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [31:0]      alu_result,
   input  logic             alu_zero,
   input  logic             alu_negative,
   input  logic             alu_carry,
   input  logic             alu_overflow,
   output logic [15:0]      conflict_cnt
);

   logic       elig0;
   logic       elig1;
   logic       grant0;
   logic       grant1;
   logic       last_grant;
   logic [3:0] alu_flags;

   // A full buffer can still accept a new op when it drains in the same cycle.
   always_comb begin
      elig0  = req0_valid && (!rsp0_valid || rsp0_ready);
      elig1  = req1_valid && (!rsp1_valid || rsp1_ready);
      grant0 = !rst && elig0 && (!elig1 || last_grant);
      grant1 = !rst && elig1 && (!elig0 || !last_grant);
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign alu_flags  = {alu_overflow, alu_carry, alu_negative, alu_zero};

   always_comb begin
      alu_a    = 32'd0;
      alu_b    = 32'd0;
      alu_ctrl = 4'd0;
      if (grant0) begin
         alu_a    = req0_a;
         alu_b    = req0_b;
         alu_ctrl = req0_op;
      end else if (grant1) begin
         alu_a    = req1_a;
         alu_b    = req1_b;
         alu_ctrl = req1_op;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp0_valid  <= 1'b0;
         rsp0_result <= '0;
         rsp0_flags  <= '0;
         rsp0_tag    <= '0;
         rsp1_valid  <= 1'b0;
         rsp1_result <= '0;
         rsp1_flags  <= '0;
         rsp1_tag    <= '0;
      end else begin
         if (grant0) begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= alu_result;
            rsp0_flags  <= alu_flags;
            rsp0_tag    <= req0_tag;
         end else if (rsp0_valid && rsp0_ready) begin
            rsp0_valid <= 1'b0;
         end
         if (grant1) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= alu_result;
            rsp1_flags  <= alu_flags;
            rsp1_tag    <= req1_tag;
         end else if (rsp1_valid && rsp1_ready) begin
            rsp1_valid <= 1'b0;
         end
      end
   end

   // last_grant resets to port 1 so that port 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant   <= 1'b1;
         conflict_cnt <= 16'd0;
      end else begin
         if (grant0) begin
            last_grant <= 1'b0;
         end else if (grant1) begin
            last_grant <= 1'b1;
         end
         if (elig0 && elig1 && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_alu_share_arbiter;

   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [31:0]      req0_a, req0_b, req1_a, req1_b;
   logic [3:0]       req0_op, req1_op;
   logic [TAG_W-1:0] req0_tag, req1_tag;
   logic             rsp0_valid, rsp1_valid;
   logic             rsp0_ready, rsp1_ready;
   logic [31:0]      rsp0_result, rsp1_result;
   logic [3:0]       rsp0_flags, rsp1_flags;
   logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
   logic [31:0]      alu_a, alu_b, alu_result;
   logic [3:0]       alu_ctrl;
   logic             alu_zero, alu_negative, alu_carry, alu_overflow;
   logic [15:0]      conflict_cnt;
   logic [35:0]      alu_out;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   // Reference ALU: returns {overflow, carry, negative, zero, result}.
   function automatic logic [35:0] alu_fn(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      logic [32:0] w;
      logic [31:0] r;
      logic c, v;
      c = 1'b0;
      v = 1'b0;
      r = 32'd0;
      w = 33'd0;
      case (op)
         4'd0: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[31:0];
            c = w[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'd1: begin
            w = {1'b0, a} - {1'b0, b};
            r = w[31:0];
            c = w[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = a << b[4:0];
         4'd6: r = a >> b[4:0];
         4'd7: r = $unsigned($signed(a) >>> b[4:0]);
         4'd8: r = {31'd0, $signed(a) < $signed(b)};
         4'd9: r = {31'd0, a < b};
         4'd15: r = b;
         default: r = 32'd0;
      endcase
      return {v, c, r[31], (r == 32'd0), r};
   endfunction

   assign alu_out = alu_fn(alu_ctrl, alu_a, alu_b);
   assign {alu_overflow, alu_carry, alu_negative, alu_zero, alu_result} = alu_out;

   alu_share_arbiter #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_tag(req1_tag),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags), .rsp0_tag(rsp0_tag),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags), .rsp1_tag(rsp1_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
      .alu_carry(alu_carry), .alu_overflow(alu_overflow),
      .conflict_cnt(conflict_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'd0; req0_tag = 4'd1;
      req1_a = 32'd3; req1_b = 32'd4; req1_op = 4'd0; req1_tag = 4'd2;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b0) $display("FAIL reset_req0_ready got %b want 0", req0_ready); else passed++;
      checks++; if (req1_ready !== 1'b0) $display("FAIL reset_req1_ready got %b want 0", req1_ready); else passed++;
      tick;
      tick;
      checks++; if (rsp0_valid !== 1'b0) $display("FAIL reset_rsp0_valid got %b want 0", rsp0_valid); else passed++;
      checks++; if (rsp1_valid !== 1'b0) $display("FAIL reset_rsp1_valid got %b want 0", rsp1_valid); else passed++;
      checks++; if (rsp0_result !== 32'd0 || rsp1_result !== 32'd0) $display("FAIL reset_result got %h/%h want 0", rsp0_result, rsp1_result); else passed++;
      checks++; if (rsp0_flags !== 4'd0 || rsp1_flags !== 4'd0) $display("FAIL reset_flags got %b/%b want 0", rsp0_flags, rsp1_flags); else passed++;
      checks++; if (rsp0_tag !== 4'd0 || rsp1_tag !== 4'd0) $display("FAIL reset_tag got %h/%h want 0", rsp0_tag, rsp1_tag); else passed++;
      checks++; if (conflict_cnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", conflict_cnt); else passed++;
      rst = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick;
   endtask

   task automatic test_overflow_add;
      req0_valid = 1'b1; req0_a = 32'h7FFFFFFF; req0_b = 32'h1;
      req0_op = 4'd0; req0_tag = 4'h3; rsp0_ready = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b1) $display("FAIL add_req0_ready got %b want 1", req0_ready); else passed++;
      checks++; if (alu_a !== 32'h7FFFFFFF || alu_b !== 32'h1 || alu_ctrl !== 4'd0) $display("FAIL add_alu_drive got %h %h %h", alu_a, alu_b, alu_ctrl); else passed++;
      tick;
      req0_valid = 1'b0;
      checks++; if (rsp0_valid !== 1'b1) $display("FAIL add_rsp0_valid got %b want 1", rsp0_valid); else passed++;
      checks++; if (rsp0_result !== 32'h80000000) $display("FAIL add_result got %h want 80000000", rsp0_result); else passed++;
      checks++; if (rsp0_flags !== 4'b1010) $display("FAIL add_flags got %b want 1010", rsp0_flags); else passed++;
      checks++; if (rsp0_tag !== 4'h3) $display("FAIL add_tag got %h want 3", rsp0_tag); else passed++;
      tick;
      checks++; if (rsp0_valid !== 1'b0) $display("FAIL add_drain got %b want 0", rsp0_valid); else passed++;
   endtask

   task automatic test_zero_sub;
      req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd5;
      req1_op = 4'd1; req1_tag = 4'h5; rsp1_ready = 1'b1;
      #1;
      checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) $display("FAIL sub_grant got %b%b want 10", req1_ready, req0_ready); else passed++;
      tick;
      req1_valid = 1'b0;
      checks++; if (rsp1_valid !== 1'b1) $display("FAIL sub_rsp1_valid got %b want 1", rsp1_valid); else passed++;
      checks++; if (rsp1_result !== 32'd0) $display("FAIL sub_result got %h want 0", rsp1_result); else passed++;
      checks++; if (rsp1_flags !== 4'b0001) $display("FAIL sub_flags got %b want 0001", rsp1_flags); else passed++;
      checks++; if (rsp1_tag !== 4'h5) $display("FAIL sub_tag got %h want 5", rsp1_tag); else passed++;
      tick;
   endtask

   task automatic test_contention;
      logic exp0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_op = 4'd0; req1_op = 4'd0;
      for (int i = 0; i < 8; i++) begin
         req0_tag = 4'(i); req1_tag = 4'(i + 8);
         req0_a = 32'(i); req0_b = 32'd100;
         req1_a = 32'(i); req1_b = 32'd200;
         exp0 = (i % 2 == 0);
         #1;
         checks++; if (req0_ready !== exp0 || req1_ready !== !exp0) $display("FAIL tie_grant cyc %0d got %b%b want %b%b", i, req0_ready, req1_ready, exp0, !exp0); else passed++;
         tick;
         if (exp0) begin
            checks++; if (rsp0_tag !== 4'(i) || rsp0_result !== 32'(i + 100)) $display("FAIL tie_rsp0 cyc %0d got %h/%h want %h/%h", i, rsp0_tag, rsp0_result, i, i + 100); else passed++;
         end else begin
            checks++; if (rsp1_tag !== 4'(i + 8) || rsp1_result !== 32'(i + 200)) $display("FAIL tie_rsp1 cyc %0d got %h/%h want %h/%h", i, rsp1_tag, rsp1_result, i + 8, i + 200); else passed++;
         end
      end
      checks++; if (conflict_cnt !== 16'd8) $display("FAIL tie_cnt got %0d want 8", conflict_cnt); else passed++;
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick;
   endtask

   task automatic test_backpressure;
      req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_op = 4'd0; req0_tag = 4'h6;
      req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_op = 4'd1; req1_tag = 4'h2;
      rsp0_ready = 1'b0; rsp1_ready = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL bp_first got %b%b want 10", req0_ready, req1_ready); else passed++;
      tick;
      checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd30 || rsp0_tag !== 4'h6) $display("FAIL bp_capture got %b %h %h want 1 1e 6", rsp0_valid, rsp0_result, rsp0_tag); else passed++;
      req0_a = 32'd99; req0_tag = 4'hE;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) $display("FAIL bp_stall cyc %0d got %b%b want 01", k, req0_ready, req1_ready); else passed++;
         tick;
         checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd30 || rsp0_tag !== 4'h6 || rsp0_flags !== 4'd0) $display("FAIL bp_hold cyc %0d got %b %h %h %b", k, rsp0_valid, rsp0_result, rsp0_tag, rsp0_flags); else passed++;
         checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'hFFFFFFFF || rsp1_flags !== 4'b0110) $display("FAIL bp_port1 cyc %0d got %b %h %b want 1 ffffffff 0110", k, rsp1_valid, rsp1_result, rsp1_flags); else passed++;
      end
      req0_a = 32'hF0; req0_b = 32'hFF; req0_op = 4'd2; req0_tag = 4'h9;
      rsp0_ready = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL bp_release got %b%b want 10", req0_ready, req1_ready); else passed++;
      tick;
      checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'hF0 || rsp0_tag !== 4'h9) $display("FAIL bp_replace got %b %h %h want 1 f0 9", rsp0_valid, rsp0_result, rsp0_tag); else passed++;
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick;
   endtask

   task automatic test_reset_midflight;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'd0; req0_tag = 4'h1;
      tick;
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 4'd3; req1_tag = 4'h2;
      tick;
      checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b1) $display("FAIL mid_fill got %b%b want 11", rsp0_valid, rsp1_valid); else passed++;
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL mid_rst_ready got %b%b want 00", req0_ready, req1_ready); else passed++;
      tick;
      rst = 1'b0;
      checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) $display("FAIL mid_valid got %b%b want 00", rsp0_valid, rsp1_valid); else passed++;
      checks++; if (conflict_cnt !== 16'd0) $display("FAIL mid_cnt got %0d want 0", conflict_cnt); else passed++;
      #1;
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL mid_tie got %b%b want 10", req0_ready, req1_ready); else passed++;
      tick;
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick;
   endtask

   task automatic test_idle;
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         req0_a = $urandom | 32'h1; req0_b = $urandom | 32'h1; req0_op = 4'd5;
         req1_a = $urandom | 32'h1; req1_b = $urandom | 32'h1; req1_op = 4'd6;
         #1;
         checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'd0) $display("FAIL idle_alu got %h %h %h want 0 0 0", alu_a, alu_b, alu_ctrl); else passed++;
         checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL idle_ready got %b%b want 00", req0_ready, req1_ready); else passed++;
         tick;
         checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || conflict_cnt !== 16'd1) $display("FAIL idle_state got %b%b cnt %0d want 00 cnt 1", rsp0_valid, rsp1_valid, conflict_cnt); else passed++;
      end
   endtask

   task automatic test_random;
      logic [3:0]       ops [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15};
      bit               v [2], r [2], e [2], g [2];
      logic [31:0]      a [2], b [2];
      logic [3:0]       op [2];
      logic [TAG_W-1:0] tg [2];
      bit               mv [2];
      logic [35:0]      mdata [2];
      logic [TAG_W-1:0] mtag [2];
      int               mlast, mcnt;
      logic [31:0]      ea, eb;
      logic [3:0]       ec;
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick;
      rst = 1'b0;
      mv = '{0, 0}; mlast = 1; mcnt = 0;
      for (int n = 0; n < 2000; n++) begin
         for (int p = 0; p < 2; p++) begin
            v[p]  = ($urandom_range(0, 3) != 0);
            r[p]  = ($urandom_range(0, 2) != 0);
            a[p]  = $urandom;
            b[p]  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
            op[p] = ops[$urandom_range(0, 10)];
            tg[p] = TAG_W'($urandom);
         end
         req0_valid = v[0]; rsp0_ready = r[0]; req0_a = a[0]; req0_b = b[0]; req0_op = op[0]; req0_tag = tg[0];
         req1_valid = v[1]; rsp1_ready = r[1]; req1_a = a[1]; req1_b = b[1]; req1_op = op[1]; req1_tag = tg[1];
         for (int p = 0; p < 2; p++) e[p] = v[p] && (!mv[p] || r[p]);
         g[0] = e[0] && (!e[1] || mlast == 1);
         g[1] = e[1] && (!e[0] || mlast == 0);
         ea = 32'd0; eb = 32'd0; ec = 4'd0;
         for (int p = 1; p >= 0; p--) if (g[p]) begin ea = a[p]; eb = b[p]; ec = op[p]; end
         #1;
         checks++; if (req0_ready !== g[0] || req1_ready !== g[1]) $display("FAIL rnd_grant cyc %0d got %b%b want %b%b", n, req0_ready, req1_ready, g[0], g[1]); else passed++;
         checks++; if (alu_a !== ea || alu_b !== eb || alu_ctrl !== ec) $display("FAIL rnd_alu cyc %0d got %h %h %h want %h %h %h", n, alu_a, alu_b, alu_ctrl, ea, eb, ec); else passed++;
         tick;
         for (int p = 0; p < 2; p++) begin
            if (g[p]) begin
               mv[p] = 1; mdata[p] = alu_fn(op[p], a[p], b[p]); mtag[p] = tg[p]; mlast = p;
            end else if (mv[p] && r[p]) begin
               mv[p] = 0;
            end
         end
         if (e[0] && e[1] && mcnt < 65535) mcnt++;
         checks++; if (rsp0_valid !== mv[0] || rsp1_valid !== mv[1]) $display("FAIL rnd_valid cyc %0d got %b%b want %b%b", n, rsp0_valid, rsp1_valid, mv[0], mv[1]); else passed++;
         if (mv[0]) begin
            checks++; if ({rsp0_flags, rsp0_result} !== mdata[0] || rsp0_tag !== mtag[0]) $display("FAIL rnd_rsp0 cyc %0d got %b %h %h want %h %h", n, rsp0_flags, rsp0_result, rsp0_tag, mdata[0], mtag[0]); else passed++;
         end
         if (mv[1]) begin
            checks++; if ({rsp1_flags, rsp1_result} !== mdata[1] || rsp1_tag !== mtag[1]) $display("FAIL rnd_rsp1 cyc %0d got %b %h %h want %h %h", n, rsp1_flags, rsp1_result, rsp1_tag, mdata[1], mtag[1]); else passed++;
         end
         checks++; if (conflict_cnt !== 16'(mcnt)) $display("FAIL rnd_cnt cyc %0d got %0d want %0d", n, conflict_cnt, mcnt); else passed++;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   initial begin
      test_reset;
      test_overflow_add;
      test_zero_sub;
      test_contention;
      test_backpressure;
      test_reset_midflight;
      test_idle;
      test_random;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
